// File: rtl/wide_add_sequencer_if.sv
// wide_add_sequencer_if: operand/result handshake bundle for wide_add_sequencer.
interface wide_add_sequencer_if #(parameter int NBYTES = 4);
    logic                  in_valid;
    logic                  in_ready;
    logic [8*NBYTES-1:0]   a_in;
    logic [8*NBYTES-1:0]   b_in;
    logic                  cin;
    logic                  sub;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*NBYTES-1:0]   sum_out;
    logic                  cout;
    logic                  ovf;
    logic                  busy;
    modport master (
        output in_valid, a_in, b_in, cin, sub, out_ready,
        input  in_ready, out_valid, sum_out, cout, ovf, busy
    );
    modport slave (
        input  in_valid, a_in, b_in, cin, sub, out_ready,
        output in_ready, out_valid, sum_out, cout, ovf, busy
    );
endinterface

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: byte-serial NBYTES-wide adder reusing one 8-bit carry-select adder.
// Define SEQ_ADD_SUB_EN to enable subtraction (A + ~B + 1) via the sub input.
module CSelectAdder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [4:0] lo, hi0, hi1;
    assign lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
    // upper nibble precomputed for both carries, low-nibble carry picks one
    assign hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    assign hi1 = hi0 + 5'd1;
    assign {cout, sum[7:4]} = lo[4] ? hi1 : hi0;
    assign sum[3:0] = lo[3:0];
endmodule

module wide_add_sequencer #(parameter int NBYTES = 4) (
    input logic clk,
    input logic rst_n,
    wide_add_sequencer_if.slave bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES) + 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, next_state;
    logic [W-1:0]  a_reg, b_reg, b_eff, sum_reg;
    logic [IW-1:0] idx;
    logic          carry, cout_reg, ovf_reg, init_carry, accept, last;
    logic [7:0]    add_sum;
    logic          add_cout;
    assign accept = state == IDLE && bus.in_valid;
    assign last   = idx == LAST;
`ifdef SEQ_ADD_SUB_EN
    logic sub_reg;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sub_reg <= 1'b0;
        else if (accept) sub_reg <= bus.sub;
    // the +1 of two's-complement negation enters as the initial carry
    assign b_eff      = sub_reg ? ~b_reg : b_reg;
    assign init_carry = bus.sub | bus.cin;
`else
    assign b_eff      = b_reg;
    assign init_carry = bus.cin;
`endif
    CSelectAdder_8bit u_add (
        .a    (a_reg[{idx, 3'b000} +: 8]),
        .b    (b_eff[{idx, 3'b000} +: 8]),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next_state;
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = bus.in_valid ? RUN : IDLE;
            RUN:     next_state = last ? DONE : RUN;
            DONE:    next_state = bus.out_ready ? IDLE : DONE;
            default: next_state = IDLE;
        endcase
    end
    always_comb begin
        bus.in_ready  = state == IDLE;
        bus.out_valid = state == DONE;
        bus.busy      = state != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (accept) begin
            a_reg <= bus.a_in;
            b_reg <= bus.b_in;
            idx   <= '0;
            carry <= init_carry;
        end else if (state == RUN) begin
            sum_reg[{idx, 3'b000} +: 8] <= add_sum;
            carry <= add_cout;
            if (last) begin
                cout_reg <= add_cout;
                ovf_reg  <= (a_reg[W-1] == b_eff[W-1]) && (add_sum[7] != a_reg[W-1]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    assign bus.sum_out = sum_reg;
    assign bus.cout    = cout_reg;
    assign bus.ovf     = ovf_reg;
endmodule
